xpb_csa_accum: RTL

//  Downstream of the 5-bit xpb lookup tables in the modular-squaring reduction path.

---
 rtl/xpb_csa_accum_if.sv | 39 +++
 rtl/xpb_csa_accum.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/xpb_csa_accum_if.sv
// Term/result handshake bundle for xpb_csa_accum.
// XPB_ACC_OVF_DETECT_EN adds the ovf flag to both modports.
interface xpb_csa_accum_if #(
  parameter int XPB_WIDTH  = 1024,
  parameter int GUARD_BITS = 8
);
  localparam int OUT_W = XPB_WIDTH + GUARD_BITS;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [XPB_WIDTH-1:0] in_term;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     out_sum;
  logic                 busy;

`ifdef XPB_ACC_OVF_DETECT_EN
  logic                 ovf;

  modport slave (
    input  in_valid, in_last, in_term, out_ready,
    output in_ready, out_valid, out_sum, busy, ovf
  );
  modport master (
    output in_valid, in_last, in_term, out_ready,
    input  in_ready, out_valid, out_sum, busy, ovf
  );
`else
  modport slave (
    input  in_valid, in_last, in_term, out_ready,
    output in_ready, out_valid, out_sum, busy
  );
  modport master (
    output in_valid, in_last, in_term, out_ready,
    input  in_ready, out_valid, out_sum, busy
  );
`endif
endinterface

// File: rtl/xpb_csa_accum.sv
// Carry-save accumulator for a frame of xpb terms, resolved by a segmented ripple adder.
// Optional overflow flag: define XPB_ACC_OVF_DETECT_EN.
module xpb_csa_accum #(
  parameter int XPB_WIDTH  = 1024,
  parameter int GUARD_BITS = 8,
  parameter int SEG_WIDTH  = 128,
  parameter int MAX_TERMS  = 32
) (
  input logic            clk,
  input logic            reset,
  xpb_csa_accum_if.slave bus
);
  localparam int OUT_W   = XPB_WIDTH + GUARD_BITS;
  localparam int NSEG    = (OUT_W + SEG_WIDTH - 1) / SEG_WIDTH;
  localparam int PAD_W   = NSEG * SEG_WIDTH;
  localparam int SEG_CW  = $clog2(NSEG + 1);
  localparam int LAST_LO = (NSEG - 1) * SEG_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_e;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   sum_q, sum_d;
  logic [OUT_W-1:0]   carry_q, carry_d;
  logic [OUT_W-1:0]   out_sum_q, out_sum_d;
  logic [SEG_CW-1:0]  seg_cnt_q, seg_cnt_d;
  logic               cin_q, cin_d;

  logic               in_ready;
  logic               accept;
  logic [OUT_W-1:0]   term;
  logic [PAD_W-1:0]   sum_pad, carry_pad;
  logic [SEG_WIDTH-1:0] seg_a, seg_b;
  logic [SEG_WIDTH:0] seg_res;
  int                 seg_lo;

  assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign accept   = bus.in_valid && in_ready;
  assign term     = OUT_W'(bus.in_term);
  assign sum_pad  = PAD_W'(sum_q);
  assign carry_pad = PAD_W'(carry_q);

  // One shared SEG_WIDTH adder, steered to the current slice.
  always_comb begin
    seg_lo = int'(seg_cnt_q) * SEG_WIDTH;
    seg_a  = '0;
    seg_b  = '0;
    if (seg_cnt_q < SEG_CW'(NSEG)) begin
      seg_a = sum_pad[seg_lo +: SEG_WIDTH];
      seg_b = carry_pad[seg_lo +: SEG_WIDTH];
    end
    seg_res = {1'b0, seg_a} + {1'b0, seg_b} + (SEG_WIDTH+1)'(cin_q);
  end

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    out_sum_d = out_sum_q;
    seg_cnt_d = seg_cnt_q;
    cin_d     = cin_q;
    case (state_q)
      IDLE: if (accept) begin
        sum_d     = term;
        carry_d   = '0;
        seg_cnt_d = '0;
        cin_d     = 1'b0;
        state_d   = bus.in_last ? RESOLVE : ACCUM;
      end
      ACCUM: if (accept) begin
        sum_d   = sum_q ^ carry_q ^ term;
        carry_d = ((sum_q & carry_q) | (sum_q & term) | (carry_q & term)) << 1;
        if (bus.in_last) begin
          seg_cnt_d = '0;
          cin_d     = 1'b0;
          state_d   = RESOLVE;
        end
      end
      RESOLVE: begin
        // seg_cnt == NSEG is a tail cycle so out_valid lands NSEG+1 edges after the last beat.
        if (seg_cnt_q == SEG_CW'(NSEG)) begin
          state_d = DONE;
        end else begin
          for (int b = 0; b < OUT_W; b++)
            if (SEG_CW'(b / SEG_WIDTH) == seg_cnt_q) out_sum_d[b] = seg_res[b % SEG_WIDTH];
          cin_d     = seg_res[SEG_WIDTH];
          seg_cnt_d = seg_cnt_q + SEG_CW'(1);
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sum_q     <= '0;
      carry_q   <= '0;
      out_sum_q <= '0;
      seg_cnt_q <= '0;
      cin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      out_sum_q <= out_sum_d;
      seg_cnt_q <= seg_cnt_d;
      cin_q     <= cin_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = out_sum_q;
  assign bus.busy      = (state_q != IDLE);

`ifdef XPB_ACC_OVF_DETECT_EN
  localparam int TC_W = $clog2(MAX_TERMS + 2);

  logic [TC_W-1:0] term_cnt_q, term_cnt_d;
  logic            ovf_q, ovf_d;

  // term_cnt saturates one past MAX_TERMS; that is all the flag needs.
  always_comb begin
    term_cnt_d = term_cnt_q;
    ovf_d      = ovf_q;
    if (accept && state_q == IDLE) begin
      term_cnt_d = TC_W'(1);
      ovf_d      = 1'b0;
    end else if (accept) begin
      if (term_cnt_q >= TC_W'(MAX_TERMS)) ovf_d = 1'b1;
      if (term_cnt_q <= TC_W'(MAX_TERMS)) term_cnt_d = term_cnt_q + TC_W'(1);
    end
    if (state_q == RESOLVE && seg_cnt_q == SEG_CW'(NSEG - 1) && seg_res[OUT_W - LAST_LO])
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      term_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      term_cnt_q <= term_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif
endmodule
